// File: rtl/hq_ml_detector.sv
// Maximum-likelihood decision stage: accumulates |y - colsum(Hq)|^2 for 16 candidates
// streamed from the Hq generator and reports the minimum-distance index.
module hq_ml_detector #(
  parameter int unsigned Q         = 8,
  parameter int unsigned N         = 16,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 y_in_valid_i,
  input  logic [N-1:0]         y_in_r_i,
  input  logic [N-1:0]         y_in_i_i,
  input  logic                 hq_in_valid_i,
  input  logic [N-1:0]         hq_in_r_i,
  input  logic [N-1:0]         hq_in_i_i,
  output logic                 busy_o,
  output logic                 det_valid_o,
  output logic [3:0]           q_hat_o,
  output logic [ACC_WIDTH-1:0] d_min_o
);

  localparam int unsigned SqW  = 2 * N + 5;
  localparam int unsigned SumW = ((SqW > ACC_WIDTH) ? SqW : ACC_WIDTH) + 1;
  localparam logic [ACC_WIDTH-1:0] AccMax = '1;

  typedef enum logic [1:0] {StIdle, StLoadY, StAccum, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           y_cnt_q, y_cnt_d;
  logic                 j_q, j_d;
  logic [1:0]           i_q, i_d;
  logic [3:0]           q_q, q_d;
  logic [N-1:0]         y_r_q [4];
  logic [N-1:0]         y_r_d [4];
  logic [N-1:0]         y_i_q [4];
  logic [N-1:0]         y_i_d [4];
  logic [N-1:0]         hold_r_q, hold_r_d, hold_i_q, hold_i_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] d_min_q, d_min_d;
  logic [3:0]           q_hat_q, q_hat_d;
  logic                 det_valid_q, det_valid_d;

  logic signed [N:0]     s_r, s_i;
  logic signed [N+1:0]   e_r, e_i;
  logic signed [2*N+3:0] e_r_w, e_i_w, sq_r, sq_i;
  logic [SqW-1:0]        sq_sum, p;
  logic [SumW-1:0]       sum;
  logic [ACC_WIDTH-1:0]  acc_sum;

  // Per-row metric: error between y[i] and the column sum, squared, rescaled, saturated into acc.
  always_comb begin
    s_r     = $signed({hold_r_q[N-1], hold_r_q}) + $signed({hq_in_r_i[N-1], hq_in_r_i});
    s_i     = $signed({hold_i_q[N-1], hold_i_q}) + $signed({hq_in_i_i[N-1], hq_in_i_i});
    e_r     = $signed({{2{y_r_q[i_q][N-1]}}, y_r_q[i_q]}) - $signed({s_r[N], s_r});
    e_i     = $signed({{2{y_i_q[i_q][N-1]}}, y_i_q[i_q]}) - $signed({s_i[N], s_i});
    e_r_w   = {{(N+2){e_r[N+1]}}, e_r};
    e_i_w   = {{(N+2){e_i[N+1]}}, e_i};
    sq_r    = e_r_w * e_r_w;
    sq_i    = e_i_w * e_i_w;
    sq_sum  = {1'b0, sq_r} + {1'b0, sq_i};
    // Sum of squares is non-negative, so a logical shift equals the arithmetic one.
    p       = sq_sum >> Q;
    sum     = SumW'(acc_q) + SumW'(p);
    acc_sum = (sum > SumW'(AccMax)) ? AccMax : sum[ACC_WIDTH-1:0];
  end

  // Next-state logic for the control FSM, counters and result registers.
  always_comb begin
    state_d     = state_q;
    y_cnt_d     = y_cnt_q;
    j_d         = j_q;
    i_d         = i_q;
    q_d         = q_q;
    y_r_d       = y_r_q;
    y_i_d       = y_i_q;
    hold_r_d    = hold_r_q;
    hold_i_d    = hold_i_q;
    acc_d       = acc_q;
    d_min_d     = d_min_q;
    q_hat_d     = q_hat_q;
    det_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          y_cnt_d = '0;
          j_d     = 1'b0;
          i_d     = '0;
          q_d     = '0;
          acc_d   = '0;
          d_min_d = AccMax;
          q_hat_d = '0;
          state_d = StLoadY;
        end
      end
      StLoadY: begin
        if (y_in_valid_i) begin
          y_r_d[y_cnt_q] = y_in_r_i;
          y_i_d[y_cnt_q] = y_in_i_i;
          y_cnt_d        = y_cnt_q + 2'd1;
          if (y_cnt_q == 2'd3) state_d = StAccum;
        end
      end
      StAccum: begin
        if (hq_in_valid_i) begin
          if (!j_q) begin
            hold_r_d = hq_in_r_i;
            hold_i_d = hq_in_i_i;
            j_d      = 1'b1;
          end else begin
            j_d = 1'b0;
            if (i_q == 2'd3) begin
              // Strict compare: ties keep the earlier (lower) candidate.
              if (acc_sum < d_min_q) begin
                d_min_d = acc_sum;
                q_hat_d = q_q;
              end
              acc_d = '0;
              i_d   = '0;
              q_d   = q_q + 4'd1;
              if (q_q == 4'd15) begin
                state_d     = StDone;
                det_valid_d = 1'b1;
              end
            end else begin
              acc_d = acc_sum;
              i_d   = i_q + 2'd1;
            end
          end
        end
      end
      StDone: begin
        if (!start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any detection in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      y_cnt_q     <= '0;
      j_q         <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      y_r_q       <= '{default: '0};
      y_i_q       <= '{default: '0};
      hold_r_q    <= '0;
      hold_i_q    <= '0;
      acc_q       <= '0;
      d_min_q     <= AccMax;
      q_hat_q     <= '0;
      det_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_cnt_q     <= y_cnt_d;
      j_q         <= j_d;
      i_q         <= i_d;
      q_q         <= q_d;
      y_r_q       <= y_r_d;
      y_i_q       <= y_i_d;
      hold_r_q    <= hold_r_d;
      hold_i_q    <= hold_i_d;
      acc_q       <= acc_d;
      d_min_q     <= d_min_d;
      q_hat_q     <= q_hat_d;
      det_valid_q <= det_valid_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign det_valid_o = det_valid_q;
  assign q_hat_o     = q_hat_q;
  assign d_min_o     = d_min_q;

endmodule
